// File: rtl/regs_uart_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_regs_pkg
// Description : Shared constants for the UART APB register block: register
//               offsets, CTRL/STAT/IER bit positions, divisor reset value,
//               read-FSM state encoding and a count-to-byte helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_regs_pkg;

  // Register offsets (paddr[4:0])
  localparam logic [4:0] c_OFF_CTRL   = 5'h00;
  localparam logic [4:0] c_OFF_DIV    = 5'h04;
  localparam logic [4:0] c_OFF_STAT   = 5'h08;
  localparam logic [4:0] c_OFF_TXDATA = 5'h0C;
  localparam logic [4:0] c_OFF_RXDATA = 5'h10;
  localparam logic [4:0] c_OFF_IER    = 5'h14;

  // CTRL bits
  localparam int c_CTRL_EN    = 0;
  localparam int c_CTRL_TXCLR = 1;
  localparam int c_CTRL_RXCLR = 2;

  // STAT bits / fields
  localparam int c_STAT_TBUSY     = 0;
  localparam int c_STAT_RXNE      = 1;
  localparam int c_STAT_TXFULL    = 2;
  localparam int c_STAT_TXEMPTY   = 3;
  localparam int c_STAT_OVF       = 4;
  localparam int c_STAT_RXCNT_LSB = 8;
  localparam int c_STAT_TXCNT_LSB = 16;

  // IER bits; the order matches the interrupt source vector {OVF, TXEMPTY, RXNE}
  localparam int c_IER_RXNE    = 0;
  localparam int c_IER_TXEMPTY = 1;
  localparam int c_IER_OVF     = 2;

  localparam logic [15:0] c_DIV_RST = 16'd868;

  // Read FSM encoding
  typedef logic [0:0] rd_state_t;
  localparam rd_state_t c_RD_IDLE = 1'b0;
  localparam rd_state_t c_RD_WAIT = 1'b1;

  // A 256-deep FIFO has a 9-bit count; the 8-bit STAT field saturates.
  function automatic logic [7:0] cnt_byte(input logic [8:0] cnt);
    return cnt[8] ? 8'hFF : cnt[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with binary wrap pointers (one extra MSB),
//               combinational head data, flush input with top priority.
// Ports       : clk, rst_n       - clock, async active-low reset
//               i_push, i_wdata  - write request and data
//               i_pop            - read request (head advances)
//               i_clr            - flush, wins over push/pop
//               o_rdata          - head entry (valid when !o_empty)
//               o_full, o_empty  - status
//               o_count          - occupancy, wptr - rptr
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic                    i_pop,
  input  logic                    i_clr,
  output logic [WIDTH-1:0]        o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/regs_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : regs_uart_fifo
// Description : APB3 CSR block for the UART: CTRL, DIV, STAT, TXDATA, RXDATA,
//               IER. TX/RX byte FIFOs towards the core, sticky RX overflow,
//               registered maskable level interrupt. Writes complete with no
//               wait state, reads with one wait state.
// Ports       : clk, rst_n                   - clock, async active-low reset
//               psel/penable/pwrite/paddr/pwdata/pstrb - APB request
//               prdata/pready/pslverr        - APB response
//               uart_en_out, uart_div_out    - core configuration
//               tx_valid/tx_data/tx_ready    - TX byte stream to core
//               tx_busy_in                   - core is shifting a frame
//               rx_valid/rx_data             - RX byte stream from core
//               irq                          - level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module regs_uart_fifo
  import uart_regs_pkg::*;
#(
  parameter int               ADDR_W     = 32,
  parameter int               DATA_W     = 32,
  parameter int               STRB_W     = DATA_W / 8,
  parameter int               FIFO_DEPTH = 8,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RST    = DIV_W'(c_DIV_RST)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              uart_en_out,
  output logic [DIV_W-1:0]  uart_div_out,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              tx_busy_in,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Registers
  rd_state_t        r_state;
  rd_state_t        w_state_nxt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd_err;
  logic              r_en;
  logic [DIV_W-1:0]  r_div;
  logic [2:0]        r_ier;
  logic              r_ovf;
  logic              r_irq;

  // Decode
  logic [4:0]        w_off;
  logic              w_addr_ok;
  logic              w_wr;
  logic              w_rd_start;
  logic              w_ctrl_wr;
  logic              w_div_wr;
  logic              w_ier_wr;
  logic              w_ovf_clr;
  logic [DIV_W-1:0]  w_div_mask;

  // FIFO side
  logic              w_tx_push, w_tx_pop, w_tx_clr, w_tx_full, w_tx_empty;
  logic [7:0]        w_tx_head;
  logic [CW-1:0]     w_tx_cnt;
  logic              w_rx_push, w_rx_pop, w_rx_clr, w_rx_full, w_rx_empty;
  logic [7:0]        w_rx_head;
  logic [CW-1:0]     w_rx_cnt;
  logic              w_ovf_set;
  logic              w_tx_valid;

  logic [DATA_W-1:0] w_stat;
  logic [DATA_W-1:0] w_rdata;
  logic [2:0]        w_irq_src;
  logic              w_unused;

  assign w_unused = ^{paddr, pwdata, pstrb};

  assign w_off      = paddr[4:0];
  assign w_addr_ok  = (w_off == c_OFF_CTRL)   || (w_off == c_OFF_DIV)    ||
                      (w_off == c_OFF_STAT)   || (w_off == c_OFF_TXDATA) ||
                      (w_off == c_OFF_RXDATA) || (w_off == c_OFF_IER);
  assign w_wr       = psel & penable & pwrite;
  assign w_rd_start = psel & penable & ~pwrite & (r_state == c_RD_IDLE);

  assign w_ctrl_wr = w_wr & (w_off == c_OFF_CTRL) & pstrb[0];
  assign w_div_wr  = w_wr & (w_off == c_OFF_DIV);
  assign w_ier_wr  = w_wr & (w_off == c_OFF_IER) & pstrb[0];
  assign w_ovf_clr = w_wr & (w_off == c_OFF_STAT) & pstrb[0] & pwdata[c_STAT_OVF];

  // Per-byte write mask for the divisor
  for (genvar b = 0; b < (DIV_W + 7) / 8; b++) begin : g_div_mask
    localparam int LO = b * 8;
    localparam int HI = ((LO + 8) > DIV_W) ? DIV_W : (LO + 8);
    assign w_div_mask[HI-1:LO] = {(HI - LO){pstrb[b]}};
  end

  // ---------------------------------------------------------------- TX path
  assign w_tx_valid = r_en & ~w_tx_empty;
  assign w_tx_push  = w_wr & (w_off == c_OFF_TXDATA) & pstrb[0] & ~w_tx_full;
  assign w_tx_pop   = w_tx_valid & tx_ready;
  assign w_tx_clr   = w_ctrl_wr & pwdata[c_CTRL_TXCLR];

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_wdata (pwdata[7:0]),
    .i_pop   (w_tx_pop),
    .i_clr   (w_tx_clr),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_cnt)
  );

  // ---------------------------------------------------------------- RX path
  assign w_rx_push = rx_valid & r_en;
  assign w_rx_pop  = w_rd_start & (w_off == c_OFF_RXDATA) & ~w_rx_empty;
  assign w_rx_clr  = w_ctrl_wr & pwdata[c_CTRL_RXCLR];
  // Byte lost only if no slot frees up this cycle.
  assign w_ovf_set = w_rx_push & w_rx_full & ~w_rx_pop;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_wdata (rx_data),
    .i_pop   (w_rx_pop),
    .i_clr   (w_rx_clr),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_cnt)
  );

  // --------------------------------------------------------- CSR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en  <= 1'b0;
      r_div <= DIV_RST;
      r_ier <= '0;
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_en  <= pwdata[c_CTRL_EN];
      if (w_div_wr)  r_div <= (r_div & ~w_div_mask) | (pwdata[DIV_W-1:0] & w_div_mask);
      if (w_ier_wr)  r_ier <= pwdata[2:0];
      // Set has priority over the W1C clear.
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      r_irq <= |(r_ier & w_irq_src);
    end
  end

  assign w_irq_src = {r_ovf, w_tx_empty, ~w_rx_empty};

  always_comb begin
    w_stat = '0;
    w_stat[c_STAT_TBUSY]   = tx_busy_in | w_tx_valid;
    w_stat[c_STAT_RXNE]    = ~w_rx_empty;
    w_stat[c_STAT_TXFULL]  = w_tx_full;
    w_stat[c_STAT_TXEMPTY] = w_tx_empty;
    w_stat[c_STAT_OVF]     = r_ovf;
    w_stat[c_STAT_RXCNT_LSB +: 8] = cnt_byte(9'(w_rx_cnt));
    w_stat[c_STAT_TXCNT_LSB +: 8] = cnt_byte(9'(w_tx_cnt));
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      c_OFF_CTRL:   w_rdata[c_CTRL_EN] = r_en;
      c_OFF_DIV:    w_rdata = DATA_W'(r_div);
      c_OFF_STAT:   w_rdata = w_stat;
      c_OFF_RXDATA: w_rdata = w_rx_empty ? '0 : DATA_W'(w_rx_head);
      c_OFF_IER:    w_rdata[2:0] = r_ier;
      default:      w_rdata = '0;
    endcase
  end

  // ------------------------------------------------------------- read FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_RD_IDLE;
      r_rdata  <= '0;
      r_rd_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_start) begin
        r_rdata  <= w_rdata;
        r_rd_err <= ~w_addr_ok;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_RD_IDLE: if (w_rd_start) w_state_nxt = c_RD_WAIT;
      c_RD_WAIT: w_state_nxt = c_RD_IDLE;
      default:   w_state_nxt = c_RD_IDLE;
    endcase
  end

  // pready is forced high while reset is asserted, even if the bus still
  // holds a read access.
  always_comb begin
    pready  = ~rst_n | ~w_rd_start;
    prdata  = (r_state == c_RD_WAIT) ? r_rdata : '0;
    pslverr = (w_wr & (~w_addr_ok | ((w_off == c_OFF_TXDATA) & w_tx_full))) |
              ((r_state == c_RD_WAIT) & r_rd_err);
  end

  assign uart_en_out  = r_en;
  assign uart_div_out = r_div;
  assign tx_valid     = w_tx_valid;
  assign tx_data      = w_tx_head;
  assign irq          = r_irq;

endmodule
`default_nettype wire
